// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that time-shares one spi_master PISO/SIPO port among
// NUM_REQ requesters, with a grant-to-response watchdog.
module spi_master_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int MAX_XFER_SIZE  = 32,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE)
) (
  input  logic                                i_sys_clk,
  input  logic                                i_sys_rst,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ*MAX_XFER_SIZE-1:0]    i_req_data,
  input  logic [NUM_REQ*XFER_CNT_WIDTH-1:0]   i_req_xfer_size,
  output logic [NUM_REQ-1:0]                  o_req_ack,
  output logic [MAX_XFER_SIZE-1:0]            o_rsp_data,
  output logic [NUM_REQ-1:0]                  o_rsp_vld,
  output logic [NUM_REQ-1:0]                  o_rsp_err,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic                                o_busy,
  output logic [MAX_XFER_SIZE-1:0]            o_piso_data,
  output logic [XFER_CNT_WIDTH-1:0]           o_piso_xfer_size,
  output logic                                o_piso_req,
  input  logic                                i_piso_ack,
  input  logic [MAX_XFER_SIZE-1:0]            i_sipo_data,
  input  logic                                i_sipo_rdy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [WD_W-1:0]   wd;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [WD_W-1:0]   wd_inc;
  logic              timeout_hit;
  logic              done;
  logic              abort;
  logic [IDX_W-1:0]  next_ptr;

  // Scan from the highest offset down so the requester closest to rr_ptr
  // is the last (winning) assignment.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign wd_inc      = (wd == '1) ? wd : wd + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_inc == WD_W'(TIMEOUT_CYCLES));
  assign done        = ((state == ISSUE) && i_piso_ack && i_sipo_rdy) ||
                       ((state == WAIT_RSP) && i_sipo_rdy);
  // A response arriving on the timeout cycle still counts as a completion.
  assign abort       = (state != IDLE) && !done && timeout_hit;
  assign next_ptr    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  assign o_req_ack   = (state == ISSUE) ? (o_grant & {NUM_REQ{i_piso_ack}}) : '0;
  assign o_busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      grant_idx        <= '0;
      wd               <= '0;
      o_grant          <= '0;
      o_piso_req       <= 1'b0;
      o_piso_data      <= '0;
      o_piso_xfer_size <= '0;
      o_rsp_data       <= '0;
      o_rsp_vld        <= '0;
      o_rsp_err        <= '0;
    end else begin
      o_rsp_vld <= '0;
      o_rsp_err <= '0;
      if (state == IDLE) begin
        if (pick_vld) begin
          state            <= ISSUE;
          grant_idx        <= pick_idx;
          o_grant          <= NUM_REQ'(1) << pick_idx;
          o_piso_data      <= i_req_data[pick_idx*MAX_XFER_SIZE +: MAX_XFER_SIZE];
          o_piso_xfer_size <= i_req_xfer_size[pick_idx*XFER_CNT_WIDTH +: XFER_CNT_WIDTH];
          o_piso_req       <= 1'b1;
          wd               <= '0;
        end
      end else begin
        wd <= wd_inc;
        if (done || abort) begin
          state      <= IDLE;
          o_piso_req <= 1'b0;
          o_grant    <= '0;
          rr_ptr     <= next_ptr;
          if (done) begin
            o_rsp_data <= i_sipo_data;
            o_rsp_vld  <= o_grant;
          end else begin
            o_rsp_err  <= o_grant;
          end
        end else if ((state == ISSUE) && i_piso_ack) begin
          state      <= WAIT_RSP;
          o_piso_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: table-driven single transfers plus
// hand-written sequences for ack/rdy overlap, timeout, reset and fairness.
`timescale 1ns/1ps
module tb_spi_master_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int SW  = 5;
  localparam int TMO = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR*SW-1:0]  req_size;
  logic [NR-1:0]     req_ack;
  logic [DW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_vld;
  logic [NR-1:0]     rsp_err;
  logic [NR-1:0]     grant;
  logic              busy;
  logic [DW-1:0]     piso_data;
  logic [SW-1:0]     piso_size;
  logic              piso_req;
  logic              piso_ack;
  logic [DW-1:0]     sipo_data;
  logic              sipo_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_arbiter #(
    .NUM_REQ(NR), .MAX_XFER_SIZE(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_req(req), .i_req_data(req_data), .i_req_xfer_size(req_size),
    .o_req_ack(req_ack), .o_rsp_data(rsp_data), .o_rsp_vld(rsp_vld),
    .o_rsp_err(rsp_err), .o_grant(grant), .o_busy(busy),
    .o_piso_data(piso_data), .o_piso_xfer_size(piso_size), .o_piso_req(piso_req),
    .i_piso_ack(piso_ack), .i_sipo_data(sipo_data), .i_sipo_rdy(sipo_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] mask;
    int            win;
    logic [DW-1:0] data;
    logic [SW-1:0] size;
    logic [DW-1:0] rsp;
    int            ack_dly;
    int            rdy_dly;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slices(input int win, input logic [DW-1:0] data, input logic [SW-1:0] size);
    for (int k = 0; k < NR; k++) begin
      req_data[k*DW +: DW] = (k == win) ? data : (32'hBAD0_0000 | DW'(k));
      req_size[k*SW +: SW] = (k == win) ? size : SW'(31 - k);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [NR-1:0] mask, input int win,
                          input logic [DW-1:0] data, input logic [SW-1:0] size,
                          input logic [DW-1:0] rsp, input int ack_dly, input int rdy_dly,
                          input bit both, input bit drop);
    logic [NR-1:0] g;
    g = NR'(1) << win;
    set_slices(win, data, size);
    req = mask;
    #1;
    check({tag, ".req_before_grant"}, piso_req, 0);
    tick();
    check({tag, ".grant"}, grant, g);
    check({tag, ".piso_req"}, piso_req, 1);
    check({tag, ".piso_data"}, piso_data, data);
    check({tag, ".piso_size"}, piso_size, size);
    check({tag, ".busy"}, busy, 1);
    if (drop) req = '0;
    repeat (ack_dly - 1) tick();
    check({tag, ".req_held"}, piso_req, 1);
    check({tag, ".data_held"}, piso_data, data);
    piso_ack = 1'b1;
    if (both) begin
      sipo_rdy  = 1'b1;
      sipo_data = rsp;
    end
    #1;
    check({tag, ".req_ack"}, req_ack, g);
    tick();
    piso_ack = 1'b0;
    sipo_rdy = 1'b0;
    req      = '0;
    #1;
    check({tag, ".ack_pulse_end"}, req_ack, 0);
    if (!both) begin
      check({tag, ".req_dropped"}, piso_req, 0);
      check({tag, ".no_early_vld"}, rsp_vld, 0);
      repeat (rdy_dly - 1) tick();
      sipo_rdy  = 1'b1;
      sipo_data = rsp;
      tick();
      sipo_rdy  = 1'b0;
      sipo_data = '0;
    end
    check({tag, ".rsp_vld"}, rsp_vld, g);
    check({tag, ".rsp_data"}, rsp_data, rsp);
    check({tag, ".rsp_err"}, rsp_err, 0);
    check({tag, ".grant_clear"}, grant, 0);
    check({tag, ".idle"}, busy, 0);
    tick();
    check({tag, ".vld_pulse_end"}, rsp_vld, 0);
    check({tag, ".rsp_hold"}, rsp_data, rsp);
  endtask

  initial begin
    #200us;
    $display("FAIL bench_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            bad_pulse;
    int            order[5];

    vecs[0] = '{4'b0010, 1, 32'hA5A5_0001, 5'd7,  32'h0000_00C3, 3, 20};
    vecs[1] = '{4'b0011, 0, 32'h1111_2222, 5'd31, 32'h8000_0001, 1, 1};
    vecs[2] = '{4'b1010, 1, 32'h3333_4444, 5'd0,  32'hFFFF_FFFF, 2, 4};
    vecs[3] = '{4'b1001, 3, 32'hCAFE_F00D, 5'd15, 32'h1234_5678, 1, 2};
    vecs[4] = '{4'b0100, 2, 32'h0BAD_BEEF, 5'd8,  32'h0000_0000, 4, 3};
    vecs[5] = '{4'b0001, 0, 32'h5555_AAAA, 5'd16, 32'hA5A5_5A5A, 2, 6};
    order   = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; req_data = '0; req_size = '0;
    piso_ack = 1'b0; sipo_rdy = 1'b0; sipo_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset.grant", grant, 0);
    check("reset.piso_req", piso_req, 0);
    check("reset.piso_data", piso_data, 0);
    check("reset.piso_size", piso_size, 0);
    check("reset.rsp_data", rsp_data, 0);
    check("reset.rsp_vld", rsp_vld, 0);
    check("reset.rsp_err", rsp_err, 0);
    check("reset.busy", busy, 0);

    // Stray handshakes while idle must not start anything.
    piso_ack = 1'b1; sipo_rdy = 1'b1; sipo_data = 32'hDEAD_DEAD;
    #1;
    check("idle_ack.req_ack", req_ack, 0);
    tick();
    piso_ack = 1'b0; sipo_rdy = 1'b0; sipo_data = '0;
    check("idle_rdy.rsp_vld", rsp_vld, 0);
    check("idle_rdy.rsp_data", rsp_data, 0);

    for (int i = 0; i < 6; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].mask, vecs[i].win, vecs[i].data,
               vecs[i].size, vecs[i].rsp, vecs[i].ack_dly, vecs[i].rdy_dly, 1'b0, 1'b0);

    // Pointer is 1 here.
    run_xfer("ack_rdy_same", 4'b0010, 1, 32'h0F0F_0F0F, 5'd3, 32'h00C0_FFEE, 2, 0, 1'b1, 1'b0);
    run_xfer("req_drop", 4'b0100, 2, 32'h7777_8888, 5'd12, 32'h9999_0000, 3, 5, 1'b0, 1'b1);

    // Timeout on requester 3: ack arrives, response never does.
    set_slices(3, 32'hDEAD_0003, 5'd9);
    req = 4'b1000;
    tick();
    check("tmo.grant", grant, 4'b1000);
    piso_ack = 1'b1;
    #1;
    check("tmo.req_ack", req_ack, 4'b1000);
    tick();
    piso_ack = 1'b0;
    req      = '0;
    bad_pulse = 1'b0;
    repeat (TMO - 2) begin
      tick();
      if (rsp_vld != '0 || rsp_err != '0) bad_pulse = 1'b1;
    end
    check("tmo.no_early_pulse", bad_pulse, 0);
    check("tmo.grant_kept", grant, 4'b1000);
    tick();
    check("tmo.rsp_err", rsp_err, 4'b1000);
    check("tmo.rsp_vld", rsp_vld, 0);
    check("tmo.grant_clear", grant, 0);
    check("tmo.piso_req", piso_req, 0);
    check("tmo.busy", busy, 0);
    tick();
    check("tmo.err_pulse_end", rsp_err, 0);
    run_xfer("after_tmo", 4'b1001, 0, 32'h2468_ACE0, 5'd4, 32'h1357_9BDF, 1, 2, 1'b0, 1'b0);

    // Reset while waiting for the response of requester 2.
    set_slices(2, 32'h4242_4242, 5'd21);
    req = 4'b0100;
    tick();
    check("rst_mid.grant", grant, 4'b0100);
    piso_ack = 1'b1;
    tick();
    piso_ack = 1'b0;
    req      = '0;
    repeat (3) tick();
    check("rst_mid.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.grant", grant, 0);
    check("rst_mid.piso_req", piso_req, 0);
    check("rst_mid.piso_data", piso_data, 0);
    check("rst_mid.piso_size", piso_size, 0);
    check("rst_mid.rsp_data", rsp_data, 0);
    check("rst_mid.busy", busy, 0);
    sipo_rdy  = 1'b1;
    sipo_data = 32'h1234_0000;
    tick();
    sipo_rdy  = 1'b0;
    sipo_data = '0;
    check("rst_mid.late_rdy_vld", rsp_vld, 0);
    check("rst_mid.late_rdy_data", rsp_data, 0);

    // Fairness from a freshly reset pointer: 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      run_xfer($sformatf("rr%0d", i), 4'b1111, order[i], 32'hF000_0000 | DW'(i),
               SW'(i + 1), 32'h0000_0100 | DW'(i), 1, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
